// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the shared data RAM.
// The arbiter takes the slave view; the requesters and the RAM model take the master view.
interface dmem_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  // requester 0: core load/store path
  logic                  Req0, We0, Lock0;
  logic [ADDR_WIDTH-1:0] Addr0;
  logic [WORD_WIDTH-1:0] Wdata0;
  logic                  Gnt0, Err0;
  logic [WORD_WIDTH-1:0] Rdata0;
  // requester 1: program/debug loader
  logic                  Req1, We1, Lock1;
  logic [ADDR_WIDTH-1:0] Addr1;
  logic [WORD_WIDTH-1:0] Wdata1;
  logic                  Gnt1, Err1;
  logic [WORD_WIDTH-1:0] Rdata1;
  // shared RAM side
  logic [ADDR_WIDTH-1:0] Ram_A;
  logic [WORD_WIDTH-1:0] Ram_WD;
  logic                  Ram_WE;
  logic [WORD_WIDTH-1:0] Ram_RD;

  modport slave (
    input  Req0, We0, Lock0, Addr0, Wdata0,
    output Gnt0, Err0, Rdata0,
    input  Req1, We1, Lock1, Addr1, Wdata1,
    output Gnt1, Err1, Rdata1,
    output Ram_A, Ram_WD, Ram_WE,
    input  Ram_RD
  );

  modport master (
    output Req0, We0, Lock0, Addr0, Wdata0,
    input  Gnt0, Err0, Rdata0,
    output Req1, We1, Lock1, Addr1, Wdata1,
    input  Gnt1, Err1, Rdata1,
    input  Ram_A, Ram_WD, Ram_WE,
    output Ram_RD
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared data RAM. A registered owner (IDLE/OWN0/OWN1)
// gets the RAM combinationally whenever it requests; ownership moves round-robin at
// each edge, with an optional lock that is capped at MAX_BURST consecutive grants.
module dmem_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ENTRIES    = 100,
  parameter int ADDR_WIDTH = $clog2(ENTRIES),
  parameter int MAX_BURST  = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  dmem_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0]       BURST_MAX = CW'(MAX_BURST - 1);
  // one extra bit so the range check still works when ENTRIES is a power of two
  localparam logic [ADDR_WIDTH:0] ENT       = ENTRIES[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          last_q,  last_d;

  logic [1:0]            req, lock, gnt;
  logic                  sel, we_sel, in_rng, any_gnt, owned, eff_last;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [WORD_WIDTH-1:0] wd_sel;

  assign req  = {bus.Req1,  bus.Req0};
  assign lock = {bus.Lock1, bus.Lock0};

  // Grant and RAM datapath mux; everything is held at zero while Rst is high so
  // no write can slip through in the reset cycle.
  always_comb begin
    gnt = 2'b00;
    if (!Rst) begin
      if (state_q == OWN0) gnt[0] = req[0];
      if (state_q == OWN1) gnt[1] = req[1];
    end
    any_gnt  = |gnt;
    sel      = (state_q == OWN1);
    addr_sel = sel ? bus.Addr1  : bus.Addr0;
    wd_sel   = sel ? bus.Wdata1 : bus.Wdata0;
    we_sel   = sel ? bus.We1    : bus.We0;
    in_rng   = ({1'b0, addr_sel} < ENT);

    bus.Gnt0   = gnt[0];
    bus.Gnt1   = gnt[1];
    bus.Err0   = gnt[0] & ~in_rng;
    bus.Err1   = gnt[1] & ~in_rng;
    bus.Ram_WE = any_gnt & we_sel & in_rng;
    bus.Ram_A  = any_gnt ? addr_sel : '0;
    bus.Ram_WD = any_gnt ? wd_sel   : '0;
    bus.Rdata0 = (gnt[0] & ~we_sel & in_rng) ? bus.Ram_RD : '0;
    bus.Rdata1 = (gnt[1] & ~we_sel & in_rng) ? bus.Ram_RD : '0;
  end

  // Next owner, burst counter and round-robin pointer. The pointer used for a tie
  // already reflects this cycle's grant, which is what gives strict alternation.
  always_comb begin
    owned    = (state_q != IDLE);
    eff_last = any_gnt ? sel : last_q;
    last_d   = eff_last;
    state_d  = state_q;
    burst_d  = burst_q;

    if (!req[0] && !req[1])
      state_d = IDLE;
    else if (owned && req[sel] && lock[sel] && (burst_q < BURST_MAX))
      state_d = state_q;
    else if (req[0] && req[1])
      state_d = eff_last ? OWN0 : OWN1;
    else
      state_d = req[0] ? OWN0 : OWN1;

    if (state_d != state_q || state_d == IDLE)
      burst_d = '0;
    else if (burst_q != BURST_MAX)
      burst_d = burst_q + 1'b1;
  end

  // Owner register; reset drops ownership and makes requester 0 win the first tie.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic from both requesters, all checked every cycle against a
// transaction-level model of the arbitration rules and a shadow copy of the RAM.
module tb_dmem_arbiter;
  localparam int WW = 32;
  localparam int ENT = 100;
  localparam int AW = 7;
  localparam int MB = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int nchk = 0;
  int npass = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.WORD_WIDTH(WW), .ENTRIES(ENT), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Ram2 stand-in: asynchronous read, write on the rising edge
  logic [WW-1:0] ram [ENT];
  initial for (int i = 0; i < ENT; i++) ram[i] = 32'hA500_0000 + i;
  assign bus.Ram_RD = (int'(bus.Ram_A) < ENT) ? ram[bus.Ram_A] : '0;
  always @(posedge Clk) if (bus.Ram_WE && int'(bus.Ram_A) < ENT) ram[bus.Ram_A] <= bus.Ram_WD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic drv(input int id, input logic rq, input logic we, input logic lk,
                     input logic [AW-1:0] a, input logic [WW-1:0] d);
    if (id == 0) begin
      bus.Req0 = rq; bus.We0 = we; bus.Lock0 = lk; bus.Addr0 = a; bus.Wdata0 = d;
    end else begin
      bus.Req1 = rq; bus.We1 = we; bus.Lock1 = lk; bus.Addr1 = a; bus.Wdata1 = d;
    end
  endtask

  // One access: present it, wait (bounded) for the grant, capture the response,
  // and advance to the next cycle with the request still asserted.
  task automatic acc(input int id, input logic we, input logic lk, input logic [AW-1:0] a,
                     input logic [WW-1:0] d, output int waited, output logic [WW-1:0] rd,
                     output logic err, output logic rwe);
    logic done;
    done = 1'b0; waited = -1; rd = '0; err = 1'b0; rwe = 1'b0;
    drv(id, 1'b1, we, lk, a, d);
    for (int k = 0; k < 20 && !done; k++) begin
      #2;
      if ((id == 0) ? bus.Gnt0 : bus.Gnt1) begin
        done = 1'b1; waited = k; rwe = bus.Ram_WE;
        rd  = (id == 0) ? bus.Rdata0 : bus.Rdata1;
        err = (id == 0) ? bus.Err0 : bus.Err1;
      end
      tick();
    end
    if (!done) begin
      nchk++;
      $display("FAIL acc_timeout: requester %0d got no grant, required one within 20 cycles", id);
    end
  endtask

  // Behavioural model: owner as an int (-1 = nobody), burst length, last winner,
  // and a shadow RAM. Evaluated on the falling edge, then advanced for the next edge.
  initial begin : model
    int own, last, cnt, g, nxt;
    int r[2], w[2], l[2], a[2];
    logic [WW-1:0] d[2];
    logic [WW-1:0] mem [ENT];
    logic [WW-1:0] e_rd[2];
    logic e_err[2], e_we;
    logic [WW-1:0] e_a, e_wd;
    own = -1; last = 1; cnt = 0;
    for (int i = 0; i < ENT; i++) mem[i] = 32'hA500_0000 + i;
    forever begin
      @(negedge Clk);
      r[0] = int'(bus.Req0); w[0] = int'(bus.We0); l[0] = int'(bus.Lock0); a[0] = int'(bus.Addr0); d[0] = bus.Wdata0;
      r[1] = int'(bus.Req1); w[1] = int'(bus.We1); l[1] = int'(bus.Lock1); a[1] = int'(bus.Addr1); d[1] = bus.Wdata1;
      g = -1;
      if (!Rst && own >= 0 && r[own] != 0) g = own;
      e_we = 1'b0; e_a = '0; e_wd = '0;
      for (int i = 0; i < 2; i++) begin
        e_err[i] = (g == i) && (a[i] >= ENT);
        e_rd[i]  = ((g == i) && w[i] == 0 && a[i] < ENT) ? mem[a[i]] : '0;
      end
      if (g >= 0) begin
        e_a = 32'(a[g]); e_wd = d[g];
        e_we = (w[g] != 0) && (a[g] < ENT);
      end
      chk("m_gnt0", {31'b0, bus.Gnt0}, {31'b0, g == 0});
      chk("m_gnt1", {31'b0, bus.Gnt1}, {31'b0, g == 1});
      chk("m_err0", {31'b0, bus.Err0}, {31'b0, e_err[0]});
      chk("m_err1", {31'b0, bus.Err1}, {31'b0, e_err[1]});
      chk("m_rdata0", bus.Rdata0, e_rd[0]);
      chk("m_rdata1", bus.Rdata1, e_rd[1]);
      chk("m_ram_we", {31'b0, bus.Ram_WE}, {31'b0, e_we});
      chk("m_ram_a", 32'(bus.Ram_A), e_a);
      chk("m_ram_wd", bus.Ram_WD, e_wd);
      if (Rst) begin
        own = -1; last = 1; cnt = 0;
      end else begin
        if (e_we) mem[a[g]] = d[g];
        if (g >= 0) last = g;
        if (r[0] == 0 && r[1] == 0)                               nxt = -1;
        else if (own >= 0 && r[own] != 0 && l[own] != 0 && cnt < MB - 1) nxt = own;
        else if (r[0] != 0 && r[1] != 0)                          nxt = 1 - last;
        else                                                      nxt = (r[0] != 0) ? 0 : 1;
        cnt = (nxt >= 0 && nxt == own) ? ((cnt < MB - 1) ? cnt + 1 : cnt) : 0;
        own = nxt;
      end
    end
  end

  // Random requester: keeps its access stable until granted, then picks a new one.
  task automatic rnd_drv(input int id, input int n);
    logic gs, rq;
    logic [AW-1:0] a;
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      gs = (id == 0) ? bus.Gnt0 : bus.Gnt1;
      rq = (id == 0) ? bus.Req0 : bus.Req1;
      @(posedge Clk); #1;
      if (!rq || gs) begin
        a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(ENT, 127)) : AW'($urandom_range(0, ENT - 1));
        drv(id, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, $urandom);
      end
    end
  endtask

  initial begin : main
    int w;
    logic [WW-1:0] rd;
    logic err, rwe;
    int ord[$];
    int i0, i1, run;
    int exp3[6] = '{1, 0, 1, 0, 1, 0};
    int exp4[6] = '{0, 0, 0, 0, 1, 0};

    // reset held with both requesting: nothing may be granted or written
    drv(0, 1'b1, 1'b1, 1'b0, 7'd0, 32'h1111);
    drv(1, 1'b1, 1'b0, 1'b0, 7'd1, 32'h0);
    Rst = 1'b1;
    repeat (2) begin
      tick(); #2;
      chk("rst_gnt0", {31'b0, bus.Gnt0}, 32'd0);
      chk("rst_gnt1", {31'b0, bus.Gnt1}, 32'd0);
      chk("rst_ram_we", {31'b0, bus.Ram_WE}, 32'd0);
    end
    tick(); Rst = 1'b0; #2;
    chk("idle_bubble_gnt0", {31'b0, bus.Gnt0}, 32'd0);
    tick(); #2;
    chk("first_tie_gnt0", {31'b0, bus.Gnt0}, 32'd1);
    chk("first_tie_gnt1", {31'b0, bus.Gnt1}, 32'd0);
    tick(); bus.Req0 = 1'b0; #2;
    chk("second_gnt1", {31'b0, bus.Gnt1}, 32'd1);
    chk("second_rdata1", bus.Rdata1, 32'hA500_0001);
    tick(); bus.Req1 = 1'b0;

    // single requester back-to-back writes then reads
    acc(0, 1'b1, 1'b0, 7'd0, 32'hFABC, w, rd, err, rwe); chk("wr0_latency", 32'(w), 32'd1);
    acc(0, 1'b1, 1'b0, 7'd4, 32'hDEFA, w, rd, err, rwe); chk("wr4_b2b", 32'(w), 32'd0);
    acc(0, 1'b1, 1'b0, 7'd8, 32'h2468, w, rd, err, rwe); chk("wr8_b2b", 32'(w), 32'd0);
    acc(0, 1'b0, 1'b0, 7'd0, 32'h0, w, rd, err, rwe); chk("rd0", rd, 32'hFABC);
    acc(0, 1'b0, 1'b0, 7'd4, 32'h0, w, rd, err, rwe); chk("rd4", rd, 32'hDEFA); chk("rd4_b2b", 32'(w), 32'd0);
    acc(0, 1'b0, 1'b0, 7'd8, 32'h0, w, rd, err, rwe); chk("rd8", rd, 32'h2468);
    bus.Req0 = 1'b0; tick();

    // alternation: requester 0 won last, so requester 1 goes first from idle
    i0 = 0; i1 = 0;
    for (int c = 0; c < 12 && ord.size() < 6; c++) begin
      drv(0, i0 < 3, 1'b1, 1'b0, 7'(20 + 2 * i0), 32'(32'h100 + i0));
      drv(1, i1 < 3, 1'b1, 1'b0, 7'(21 + 2 * i1), 32'(32'h200 + i1));
      #2;
      if (bus.Gnt0) begin ord.push_back(0); i0++; end
      if (bus.Gnt1) begin ord.push_back(1); i1++; end
      tick();
    end
    chk("alt_count", 32'(ord.size()), 32'd6);
    for (int k = 0; k < 6 && k < ord.size(); k++) chk($sformatf("alt_order%0d", k), 32'(ord[k]), 32'(exp3[k]));
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc(0, 1'b0, 1'b0, 7'(20 + 2 * k), 32'h0, w, rd, err, rwe); chk("alt_rb0", rd, 32'(32'h100 + k));
      acc(0, 1'b0, 1'b0, 7'(21 + 2 * k), 32'h0, w, rd, err, rwe); chk("alt_rb1", rd, 32'(32'h200 + k));
    end
    bus.Req0 = 1'b0; tick();

    // burst lock: four locked grants to 0, forced yield to 1, back to 0
    ord.delete();
    for (int c = 0; c < 14 && ord.size() < 6; c++) begin
      drv(0, 1'b1, 1'b0, 1'b1, 7'(ord.size()), 32'h0);
      drv(1, ord.size() > 0, 1'b0, 1'b0, 7'd50, 32'h0);
      #2;
      if (bus.Gnt0) ord.push_back(0);
      if (bus.Gnt1) ord.push_back(1);
      tick();
    end
    chk("burst_count", 32'(ord.size()), 32'd6);
    for (int k = 0; k < 6 && k < ord.size(); k++) chk($sformatf("burst_order%0d", k), 32'(ord[k]), 32'(exp4[k]));
    bus.Req1 = 1'b0;
    run = 0;
    for (int c = 0; c < 7; c++) begin
      #2; if (bus.Gnt0) run++;
      tick();
    end
    chk("burst_saturate_run", 32'(run), 32'd7);
    bus.Req0 = 1'b0; bus.Lock0 = 1'b0; tick();

    // out-of-range accesses are granted, flagged and have no effect
    acc(1, 1'b1, 1'b0, 7'd100, 32'h1234, w, rd, err, rwe);
    chk("oor_err1", {31'b0, err}, 32'd1);
    chk("oor_ram_we", {31'b0, rwe}, 32'd0);
    bus.Req1 = 1'b0;
    acc(0, 1'b0, 1'b0, 7'd0, 32'h0, w, rd, err, rwe); chk("oor_rd0_intact", rd, 32'hFABC);
    acc(0, 1'b0, 1'b0, 7'd127, 32'h0, w, rd, err, rwe);
    chk("oor_rd127_err", {31'b0, err}, 32'd1);
    chk("oor_rd127_data", rd, 32'd0);
    bus.Req0 = 1'b0; tick();

    // reset during the second locked write: it must not land, and 0 wins the tie after
    acc(0, 1'b1, 1'b1, 7'd30, 32'hAAAA, w, rd, err, rwe);
    drv(0, 1'b1, 1'b1, 1'b1, 7'd31, 32'hBBBB);
    Rst = 1'b1; #2;
    chk("midrst_gnt0", {31'b0, bus.Gnt0}, 32'd0);
    chk("midrst_ram_we", {31'b0, bus.Ram_WE}, 32'd0);
    tick(); Rst = 1'b0;
    drv(0, 1'b1, 1'b0, 1'b0, 7'd31, 32'h0);
    drv(1, 1'b1, 1'b0, 1'b0, 7'd30, 32'h0);
    tick(); #2;
    chk("postrst_gnt0", {31'b0, bus.Gnt0}, 32'd1);
    chk("postrst_gnt1", {31'b0, bus.Gnt1}, 32'd0);
    chk("postrst_rd31", bus.Rdata0, 32'hA500_001F);
    tick(); bus.Req0 = 1'b0; #2;
    chk("postrst_rd30", bus.Rdata1, 32'hAAAA);
    tick(); bus.Req1 = 1'b0; tick();

    // random traffic with occasional reset pulses
    fork
      rnd_drv(0, 1500);
      rnd_drv(1, 1500);
      begin : rstgen
        for (int c = 0; c < 1500; c++) begin
          @(posedge Clk); #1;
          Rst = ($urandom_range(0, 199) == 0);
        end
      end
    join
    #1; Rst = 1'b0; bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
